dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer that shares the single-ported data memory (128 × 32-bit RAM plus LED/switch MMIO) between the CPU load/store unit (port 0) and the debug/program-loader port (port 1). It accepts one request at a time, arbitrates round-robin on contention, and checks address legality and alignment before strobing the memory. It drives the memory's `memread`/`memwrite`/`addr`/`writedata` pins and returns registered read data with a completion pulse.

## Interface
- `RAM_LIMIT`, default 32'h0000_0200: first address past RAM.
- `LED_ADDR`, default 32'hFFFF_0000: LED write word.
- `SW_ADDR`, default 32'hFFFF_0100: switch read word.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `p0_req`, `p1_req` in 1: request; held with its fields until granted.
- `p0_we`, `p1_we` in 1: 1 = write, 0 = read.
- `p0_addr`, `p1_addr` in 32: byte address.
- `p0_wdata`, `p1_wdata` in 32: write data.
- `p0_gnt`, `p1_gnt` out 1: combinational grant, one cycle, in IDLE only.
- `p0_rvalid`, `p1_rvalid` out 1: registered completion pulse, one cycle.
- `p0_err`, `p1_err` out 1: valid with rvalid; access rejected.
- `p0_rdata`, `p1_rdata` out 32: read data, valid with rvalid; 0 for writes and errors.
- `mem_memread`, `mem_memwrite` out 1: memory strobes.
- `mem_addr`, `mem_writedata` out 32: memory address and data.
- `mem_readdata` in 32: combinational memory read data.

## Operation
- FSM: IDLE → ACCESS → DONE → IDLE.
- IDLE: if any `req` is high, pick a winner, assert its `gnt`, latch we/addr/wdata/port/legality into command registers, and go to ACCESS. Otherwise stay.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting: the port not granted last wins.
  - `last_gnt` updates on every grant.
- Legality, computed on the winner at grant:
  - Illegal if `addr[1:0]` ≠ 0.
  - A read is legal if `addr` < RAM_LIMIT or `addr` == SW_ADDR.
  - A write is legal if `addr` < RAM_LIMIT or `addr` == LED_ADDR.
  - Everything else is illegal, including writes to SW_ADDR and reads of LED_ADDR.
- ACCESS:
  - Legal access: drive `mem_addr`/`mem_writedata` from the latched command, and assert `mem_memwrite` (write) or `mem_memread` (read).
  - Illegal access: both strobes stay 0.
  - On the closing edge, capture `mem_readdata` into the winner's rdata register for a legal read, otherwise capture 0. Set the winner's `rvalid` and set `err` = illegal.
- DONE: `rvalid`/`err`/`rdata` are visible for exactly one cycle, then return to IDLE. No grants are issued in ACCESS or DONE.
- `mem_addr`/`mem_writedata` hold the last command outside ACCESS; only the strobes qualify them.
- `pX_rdata` holds its value until that port's next completion.

## Timing
- Uncontended request high in cycle 0:
  - `gnt` in cycle 0.
  - Memory strobe in cycle 1; the write commits at the end of cycle 1.
  - `rvalid` in cycle 2.
- Peak rate is one access per 3 cycles. A request held through DONE is granted in the following IDLE cycle.
- Reset values: state IDLE, `last_gnt` = 1 (port 0 wins the first tie), all `gnt`/`rvalid`/`err`/strobes 0, rdata registers 0, command registers 0.
- Reset in ACCESS: `mem_memwrite` and `mem_memread` are gated with `rst_n`, so a write is not committed on the reset edge. Any pending completion is dropped, with no `rvalid`.
- `req` dropped before `gnt`: the request is withdrawn, with no side effects.
- Addresses are compared as unsigned 32-bit values. 0x1FC is legal RAM; 0x200 is illegal.

## Structure
- Package `dmem_pkg`:
  - State enum `{IDLE, ACCESS, DONE}`.
  - Default constants RAM_LIMIT, LED_ADDR, SW_ADDR.
  - Port-index constants CPU_PORT = 0, DBG_PORT = 1.
- Sub-module `rr_arb2`: 2-requester round-robin with `last_gnt` state. Inputs are req[1:0] and an enable; output is a one-hot grant. It updates `last_gnt` only when enabled and granting.
- Legality check and FSM stay in the top level.

## Test plan
- Port 0 writes 0xDEADBEEF to 0x10, then reads 0x10 → memory strobes in cycles 1 and 4, `p0_rdata` = 0xDEADBEEF with `rvalid` in cycle 5, `err` = 0.
- Both ports request in the same cycle after reset, with requests held → grants go p0, p1, p0 on successive IDLE cycles, 3 cycles apart.
- Port 1 writes 0xA5 to 0xFFFF0000 → `mem_memwrite` high one cycle with `mem_addr` = 0xFFFF0000; LED = 0xA5.
- Illegal accesses: read 0x200, write 0xFFFF0100, read 0x12 → no strobes, `err` = 1, rdata = 0.
- Port 0 read of 0xFFFF0100 with switches = 0x3C → `p0_rdata` = 0x0000003C.
- `rst_n` low during ACCESS of a write of 0x1234 to 0x20 → memory word 0x20 unchanged, no `rvalid`, FSM in IDLE, all outputs 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned NUM_PORTS = 2;

    localparam logic [ADDR_W-1:0] DEF_RAM_LIMIT = 32'h0000_0200;
    localparam logic [ADDR_W-1:0] DEF_LED_ADDR  = 32'hFFFF_0000;
    localparam logic [ADDR_W-1:0] DEF_SW_ADDR   = 32'hFFFF_0100;

    localparam int unsigned CPU_PORT = 0;
    localparam int unsigned DBG_PORT = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Latched command for the access in flight.
    typedef struct packed {
        logic              we;
        logic              port;
        logic              legal;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester ports and memory pins of the data-memory arbiter.
interface dmem_arbiter_if;
    import dmem_pkg::*;

    logic              p0_req,    p1_req;
    logic              p0_we,     p1_we;
    logic [ADDR_W-1:0] p0_addr,   p1_addr;
    logic [DATA_W-1:0] p0_wdata,  p1_wdata;
    logic              p0_gnt,    p1_gnt;
    logic              p0_rvalid, p1_rvalid;
    logic              p0_err,    p1_err;
    logic [DATA_W-1:0] p0_rdata,  p1_rdata;
    logic              mem_memread, mem_memwrite;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata;

    // Arbiter side.
    modport slave (
        input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
               p0_wdata, p1_wdata, mem_readdata,
        output p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err,
               p0_rdata, p1_rdata, mem_memread, mem_memwrite,
               mem_addr, mem_writedata
    );

    // Requester / memory side.
    modport master (
        output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
               p0_wdata, p1_wdata, mem_readdata,
        input  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err,
               p0_rdata, p1_rdata, mem_memread, mem_memwrite,
               mem_addr, mem_writedata
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the port not granted last wins a tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt_c
);

    logic last_gnt_q, last_gnt_d;

    // One-hot grant, only while enabled.
    always_comb begin
        gnt_c = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt_c = 2'b01;
                2'b10:   gnt_c = 2'b10;
                2'b11:   gnt_c = last_gnt_q ? 2'b01 : 2'b10;
                default: gnt_c = 2'b00;
            endcase
        end
    end

    // Remember the most recent winner.
    always_comb begin
        last_gnt_d = last_gnt_q;
        if (|gnt_c) begin
            last_gnt_d = gnt_c[1];
        end
    end

    // Port 0 wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the CPU and debug ports.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RAM_LIMIT = DEF_RAM_LIMIT,
    parameter logic [ADDR_W-1:0] LED_ADDR  = DEF_LED_ADDR,
    parameter logic [ADDR_W-1:0] SW_ADDR   = DEF_SW_ADDR
) (
    input logic           clk,
    input logic           rst_n,
    dmem_arbiter_if.slave bus
);

    state_e                 state_q, state_d;
    cmd_t                   cmd_q, cmd_d;
    logic [DATA_W-1:0]      p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0]      p1_rdata_q, p1_rdata_d;
    logic [NUM_PORTS-1:0]   rvalid_q, rvalid_d;
    logic [NUM_PORTS-1:0]   err_q, err_d;
    logic [NUM_PORTS-1:0]   req_c, gnt_c;
    logic                   arb_en_c, access_c;
    logic                   win_port_c, win_we_c, win_legal_c;
    logic [ADDR_W-1:0]      win_addr_c;
    logic [DATA_W-1:0]      win_wdata_c, cap_data_c;

    assign req_c = {bus.p1_req, bus.p0_req};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en_c),
        .req   (req_c),
        .gnt_c (gnt_c)
    );

    // Select the winning requester's fields.
    always_comb begin
        win_port_c  = gnt_c[DBG_PORT];
        win_we_c    = win_port_c ? bus.p1_we    : bus.p0_we;
        win_addr_c  = win_port_c ? bus.p1_addr  : bus.p0_addr;
        win_wdata_c = win_port_c ? bus.p1_wdata : bus.p0_wdata;
    end

    // Aligned RAM is always legal; MMIO words only in their own direction.
    always_comb begin
        win_legal_c = 1'b0;
        if (win_addr_c[1:0] == 2'b00) begin
            if (win_addr_c < RAM_LIMIT) begin
                win_legal_c = 1'b1;
            end else if (win_we_c) begin
                win_legal_c = (win_addr_c == LED_ADDR);
            end else begin
                win_legal_c = (win_addr_c == SW_ADDR);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: one access per IDLE -> ACCESS -> DONE round.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req_c) state_d = ACCESS;
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded controls.
    always_comb begin
        arb_en_c = 1'b0;
        access_c = 1'b0;
        case (state_q)
            IDLE:    arb_en_c = 1'b1;
            ACCESS:  access_c = 1'b1;
            default: ;
        endcase
    end

    // Command latch on grant, completion capture at the end of ACCESS.
    always_comb begin
        cmd_d      = cmd_q;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
        rvalid_d   = '0;
        err_d      = '0;
        cap_data_c = (cmd_q.legal && !cmd_q.we) ? bus.mem_readdata : '0;
        if (|gnt_c) begin
            cmd_d = '{we: win_we_c, port: win_port_c, legal: win_legal_c,
                      addr: win_addr_c, wdata: win_wdata_c};
        end
        if (access_c) begin
            rvalid_d[cmd_q.port] = 1'b1;
            err_d[cmd_q.port]    = ~cmd_q.legal;
            if (cmd_q.port) begin
                p1_rdata_d = cap_data_c;
            end else begin
                p0_rdata_d = cap_data_c;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_q      <= '0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
            rvalid_q   <= '0;
            err_q      <= '0;
        end else begin
            cmd_q      <= cmd_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
        end
    end

    // Strobes are gated with rst_n so a reset edge never commits a write.
    assign bus.mem_memread   = access_c & cmd_q.legal & ~cmd_q.we & rst_n;
    assign bus.mem_memwrite  = access_c & cmd_q.legal &  cmd_q.we & rst_n;
    assign bus.mem_addr      = cmd_q.addr;
    assign bus.mem_writedata = cmd_q.wdata;

    assign bus.p0_gnt    = gnt_c[CPU_PORT];
    assign bus.p1_gnt    = gnt_c[DBG_PORT];
    assign bus.p0_rvalid = rvalid_q[CPU_PORT];
    assign bus.p1_rvalid = rvalid_q[DBG_PORT];
    assign bus.p0_err    = err_q[CPU_PORT];
    assign bus.p1_err    = err_q[DBG_PORT];
    assign bus.p0_rdata  = p0_rdata_q;
    assign bus.p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter with a transaction-level model.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic chk_en = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if bus ();

    dmem_arbiter #(
        .RAM_LIMIT (32'h0000_0200),
        .LED_ADDR  (32'hFFFF_0000),
        .SW_ADDR   (32'hFFFF_0100)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memory environment: RAM, LED register, switches.
    logic [31:0] ram [128] = '{default: 32'h0};
    logic [31:0] led = 32'h0;
    logic [31:0] sw;
    int          n_rd = 0;
    int          n_wr = 0;

    always_comb begin
        if (bus.mem_addr < 32'h200)             bus.mem_readdata = ram[bus.mem_addr[8:2]];
        else if (bus.mem_addr == 32'hFFFF_0100) bus.mem_readdata = sw;
        else                                    bus.mem_readdata = 32'hBAD0_0000 ^ bus.mem_addr;
    end

    always @(posedge clk) begin
        if (bus.mem_memwrite) begin
            n_wr <= n_wr + 1;
            if (bus.mem_addr < 32'h200)             ram[bus.mem_addr[8:2]] <= bus.mem_writedata;
            else if (bus.mem_addr == 32'hFFFF_0000) led <= bus.mem_writedata;
        end
        if (bus.mem_memread) n_rd <= n_rd + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Access rules written directly from the address map.
    function automatic logic legal_f(input logic we, input logic [31:0] a);
        if (a % 4 != 0)     return 1'b0;
        if (a < 32'h200)    return 1'b1;
        if (we)             return a == 32'hFFFF_0000;
        return a == 32'hFFFF_0100;
    endfunction

    // Transaction model: phase counts cycles since the grant (0 = ready).
    int          m_phase = 0;
    logic        m_last = 1'b1;
    logic        m_we = 1'b0, m_port = 1'b0, m_legal = 1'b0;
    logic [31:0] m_addr = 32'h0, m_wdata = 32'h0;
    logic [31:0] m_rdata [2] = '{default: 32'h0};
    logic [31:0] m_ram [128] = '{default: 32'h0};
    logic [31:0] m_led = 32'h0;

    always @(negedge clk) begin : cmp
        logic [1:0]  r, e_gnt, e_rv, e_err;
        logic        e_rd, e_wr, w;
        logic [31:0] v;
        r     = {bus.p1_req, bus.p0_req};
        e_gnt = 2'b00; e_rv = 2'b00; e_err = 2'b00; e_rd = 1'b0; e_wr = 1'b0;
        w     = (r == 2'b11) ? ~m_last : r[1];
        if (m_phase == 0 && r != 2'b00) e_gnt[w] = 1'b1;
        if (m_phase == 1 && m_legal && rst_n) begin
            e_rd = ~m_we;
            e_wr = m_we;
        end
        if (m_phase == 2) begin
            e_rv[m_port]  = 1'b1;
            e_err[m_port] = ~m_legal;
        end
        if (chk_en) begin
            chk("p0_gnt",    32'(bus.p0_gnt),       32'(e_gnt[0]));
            chk("p1_gnt",    32'(bus.p1_gnt),       32'(e_gnt[1]));
            chk("memread",   32'(bus.mem_memread),  32'(e_rd));
            chk("memwrite",  32'(bus.mem_memwrite), 32'(e_wr));
            chk("mem_addr",  bus.mem_addr,          m_addr);
            chk("mem_wdata", bus.mem_writedata,     m_wdata);
            chk("p0_rvalid", 32'(bus.p0_rvalid),    32'(e_rv[0]));
            chk("p1_rvalid", 32'(bus.p1_rvalid),    32'(e_rv[1]));
            chk("p0_err",    32'(bus.p0_err),       32'(e_err[0]));
            chk("p1_err",    32'(bus.p1_err),       32'(e_err[1]));
            chk("p0_rdata",  bus.p0_rdata,          m_rdata[0]);
            chk("p1_rdata",  bus.p1_rdata,          m_rdata[1]);
        end
        // Advance to the state after the coming rising edge.
        if (!rst_n) begin
            m_phase = 0; m_last = 1'b1; m_we = 1'b0; m_port = 1'b0; m_legal = 1'b0;
            m_addr = 32'h0; m_wdata = 32'h0; m_rdata[0] = 32'h0; m_rdata[1] = 32'h0;
        end else if (m_phase == 0) begin
            if (r != 2'b00) begin
                m_port  = w;
                m_we    = w ? bus.p1_we    : bus.p0_we;
                m_addr  = w ? bus.p1_addr  : bus.p0_addr;
                m_wdata = w ? bus.p1_wdata : bus.p0_wdata;
                m_legal = legal_f(m_we, m_addr);
                m_last  = w;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            v = 32'h0;
            if (m_legal && !m_we) v = (m_addr < 32'h200) ? m_ram[m_addr[8:2]] : sw;
            if (m_legal && m_we) begin
                if (m_addr < 32'h200) m_ram[m_addr[8:2]] = m_wdata;
                else                  m_led = m_wdata;
            end
            m_rdata[m_port] = v;
            m_phase = 2;
        end else begin
            m_phase = 0;
        end
    end

    task automatic set_req(input int p, input logic rq, input logic we,
                           input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            bus.p0_req = rq; bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = d;
        end else begin
            bus.p1_req = rq; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d;
        end
    endtask

    function automatic logic get_gnt(input int p);
        return (p == 0) ? bus.p0_gnt : bus.p1_gnt;
    endfunction

    // One complete access, entered and left just after a rising edge.
    task automatic access(input int p, input logic we, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output int glat, output int lat);
        logic got, done;
        got = 1'b0; done = 1'b0; glat = 0; lat = 0; rd = 32'h0; er = 1'b0;
        set_req(p, 1'b1, we, a, d);
        while (!got && glat < 20) begin
            #7;
            got = get_gnt(p);
            @(posedge clk); #1;
            if (!got) glat++;
        end
        set_req(p, 1'b0, we, a, d);
        chk("gnt_seen", 32'(got), 32'd1);
        while (got && !done && lat < 10) begin
            #7;
            lat++;
            if ((p == 0) ? bus.p0_rvalid : bus.p1_rvalid) begin
                done = 1'b1;
                rd   = (p == 0) ? bus.p0_rdata : bus.p1_rdata;
                er   = (p == 0) ? bus.p0_err   : bus.p1_err;
            end
            @(posedge clk); #1;
        end
        chk("rvalid_seen", 32'(done), 32'd1);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 7))
            0, 1:    return 32'($urandom_range(0, 127)) * 4;
            2:       return 32'($urandom_range(0, 511));
            3:       return 32'h0000_01FC;
            4:       return 32'h0000_0200;
            5:       return 32'hFFFF_0000;
            6:       return 32'hFFFF_0100;
            default: return $urandom;
        endcase
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] rd;
        logic        er;
        int          glat, lat, s_rd, s_wr;
        logic [1:0]  glog [9];
        logic [1:0]  gseen;
        int          mism;

        rst_n = 1'b0; sw = 32'h0;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        chk_en = 1'b1;
        #7;
        chk("rst_rvalid",  32'({bus.p0_rvalid, bus.p1_rvalid}), 32'd0);
        chk("rst_strobes", 32'({bus.mem_memread, bus.mem_memwrite}), 32'd0);
        chk("rst_rdata",   bus.p0_rdata | bus.p1_rdata, 32'h0);
        chk("rst_addr",    bus.mem_addr, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Write then read back on port 0.
        s_wr = n_wr;
        access(0, 1'b1, 32'h10, 32'hDEAD_BEEF, rd, er, glat, lat);
        chk("wr_glat", 32'(glat), 32'd0);
        chk("wr_lat",  32'(lat), 32'd2);
        chk("wr_err",  32'(er), 32'd0);
        chk("wr_strobes", 32'(n_wr - s_wr), 32'd1);
        access(0, 1'b0, 32'h10, 32'h0, rd, er, glat, lat);
        chk("rd_glat", 32'(glat), 32'd0);
        chk("rd_lat",  32'(lat), 32'd2);
        chk("rd_data", rd, 32'hDEAD_BEEF);
        chk("rd_err",  32'(er), 32'd0);

        // Contention right after reset, requests held.
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'h14, 32'h0);
        for (int c = 0; c < 9; c++) begin
            #7;
            glog[c] = {bus.p1_gnt, bus.p0_gnt};
            @(posedge clk); #1;
        end
        set_req(0, 1'b0, 1'b0, 32'h10, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h14, 32'h0);
        for (int c = 0; c < 9; c++) begin
            chk($sformatf("rr_gnt_c%0d", c), 32'(glog[c]),
                (c == 0 || c == 6) ? 32'd1 : ((c == 3) ? 32'd2 : 32'd0));
        end

        // LED write from port 1.
        s_wr = n_wr;
        access(1, 1'b1, 32'hFFFF_0000, 32'h0000_00A5, rd, er, glat, lat);
        chk("led_err",  32'(er), 32'd0);
        chk("led_val",  led, 32'h0000_00A5);
        chk("led_strb", 32'(n_wr - s_wr), 32'd1);

        // Rejected accesses: no strobes, err set, rdata zero.
        s_rd = n_rd; s_wr = n_wr;
        access(0, 1'b0, 32'h0000_0200, 32'h0, rd, er, glat, lat);
        chk("ill_200_err", 32'(er), 32'd1);
        chk("ill_200_rd",  rd, 32'h0);
        access(1, 1'b1, 32'hFFFF_0100, 32'h5555_5555, rd, er, glat, lat);
        chk("ill_swwr_err", 32'(er), 32'd1);
        chk("ill_swwr_rd",  rd, 32'h0);
        access(0, 1'b0, 32'h0000_0012, 32'h0, rd, er, glat, lat);
        chk("ill_mis_err", 32'(er), 32'd1);
        chk("ill_mis_rd",  rd, 32'h0);
        access(1, 1'b0, 32'hFFFF_0000, 32'h0, rd, er, glat, lat);
        chk("ill_ledrd_err", 32'(er), 32'd1);
        chk("ill_strobes", 32'((n_rd - s_rd) + (n_wr - s_wr)), 32'd0);

        // Last RAM word is legal.
        access(1, 1'b1, 32'h0000_01FC, 32'h1357_9BDF, rd, er, glat, lat);
        access(0, 1'b0, 32'h0000_01FC, 32'h0, rd, er, glat, lat);
        chk("top_word_rd",  rd, 32'h1357_9BDF);
        chk("top_word_err", 32'(er), 32'd0);

        // Switch read.
        sw = 32'h0000_003C;
        access(0, 1'b0, 32'hFFFF_0100, 32'h0, rd, er, glat, lat);
        chk("sw_rd",  rd, 32'h0000_003C);
        chk("sw_err", 32'(er), 32'd0);

        // Reset while a write is in ACCESS.
        set_req(0, 1'b1, 1'b1, 32'h20, 32'h0000_1234);
        #7;
        chk("rst_acc_gnt", 32'(bus.p0_gnt), 32'd1);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b1, 32'h20, 32'h0000_1234);
        rst_n = 1'b0;
        #7;
        chk("rst_acc_wr", 32'(bus.mem_memwrite), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #7;
            chk("rst_acc_out", 32'({bus.p0_gnt, bus.p1_gnt, bus.p0_rvalid, bus.p1_rvalid,
                                    bus.p0_err, bus.p1_err, bus.mem_memread, bus.mem_memwrite}), 32'd0);
            chk("rst_acc_rdata", bus.p0_rdata | bus.p1_rdata, 32'h0);
            chk("rst_acc_addr",  bus.mem_addr, 32'h0);
            @(posedge clk); #1;
        end
        chk("rst_acc_mem", ram[8], 32'h0);

        // Randomized traffic with occasional withdrawals and resets.
        gseen = 2'b00;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                bus.p0_req = 1'b0;
                bus.p1_req = 1'b0;
            end else begin
                rst_n = 1'b1;
                for (int p = 0; p < 2; p++) begin
                    logic cur;
                    cur = (p == 0) ? bus.p0_req : bus.p1_req;
                    if (cur && gseen[p]) begin
                        if ($urandom_range(0, 1) == 0)
                            set_req(p, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
                        else if (p == 0) bus.p0_req = 1'b0;
                        else             bus.p1_req = 1'b0;
                    end else if (cur && $urandom_range(0, 19) == 0) begin
                        if (p == 0) bus.p0_req = 1'b0;
                        else        bus.p1_req = 1'b0;
                    end else if (!cur && $urandom_range(0, 2) == 0) begin
                        set_req(p, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
                    end
                end
            end
            if ($urandom_range(0, 15) == 0) sw = $urandom;
            #7;
            gseen = {bus.p1_gnt, bus.p0_gnt};
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        bus.p0_req = 1'b0;
        bus.p1_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        mism = 0;
        for (int i = 0; i < 128; i++) if (ram[i] !== m_ram[i]) mism++;
        chk("ram_image", 32'(mism), 32'd0);
        chk("led_final", led, m_led);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
